lfsr_tick_sched: RTL and testbench
==================================

# lfsr_tick_sched

Programmable event scheduler built around a 7-bit maximal-length shift-register counter of the same family as the small pseudo-random counters (ctr_pr*). It accepts a command (terminal pattern, prescale, mode) over a valid/ready handshake. It then advances the shift counter on gated clock-enable ticks and emits a one-cycle event pulse each time the counter reaches the programmed pattern. It sits between a host/config register block and any consumer needing cheap periodic or one-shot timing, such as baud strobes, watchdog kicks or sample triggers.

## Interface

Parameters:
- PRE_W, 8, width of the prescaler reload value.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  tick enable. When low, the prescaler and LFSR freeze.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high exactly when the FSM is in IDLE.
- cmd_term  in  7  terminal LFSR pattern, sampled on command accept.
- cmd_pre  in  PRE_W  prescale reload, sampled on accept. A step occurs every cmd_pre+1 enabled cycles.
- cmd_periodic  in  1  1 = periodic, 0 = one-shot. Sampled on accept.
- stop  in  1  abort request, honoured in RUN only.
- busy  out  1  high in RUN.
- evt  out  1  one-cycle registered event pulse.
- err  out  1  sticky flag: the last accepted command had cmd_term = 0.
- lfsr  out  7  current counter state.

## Operation

- LFSR step: lfsr_next = {lfsr[5:0], lfsr[6]^lfsr[5]}. The seed is 7'b0000001. The period is 127, and the all-zero state is unreachable.
- FSM states are IDLE and RUN.
- IDLE:
  - cmd_ready = 1, busy = 0.
  - On cmd_valid, latch term, pre and periodic.
  - If cmd_term == 0: set err = 1 and stay in IDLE.
  - Otherwise: clear err, set lfsr <= seed, set pre_cnt <= cmd_pre, and go to RUN.
- RUN, each cycle with en = 1:
  - If pre_cnt != 0: pre_cnt decrements.
  - If pre_cnt == 0: pre_cnt reloads and the LFSR steps.
- Match on a step: if lfsr_next == term, the step does not load term. Instead:
  - lfsr <= seed and evt <= 1.
  - One-shot: go to IDLE.
  - Periodic: remain in RUN.
  - The term pattern therefore never appears on lfsr in RUN.
- Event spacing: N = number of steps from the seed to term (1..127). With term == seed, N = 127. The event interval is N*(pre+1) enabled cycles.
- stop in RUN: next state is IDLE, the LFSR holds its value and the prescaler halts. If stop and a match occur in the same cycle, stop wins and evt stays 0.
- stop in IDLE: ignored. A simultaneous cmd_valid is still accepted.
- cmd_valid in RUN: ignored (cmd_ready = 0). There is no queuing.
- en = 0 in RUN: no decrement, no step and no evt. The FSM still reacts to stop.
- IDLE after a one-shot or a stop: lfsr keeps its last value (the seed after a one-shot).

## Timing

- Reset values:
  - State IDLE.
  - cmd_ready = 1, busy = 0, evt = 0, err = 0.
  - lfsr = 7'b0000001, pre_cnt = 0.
  - Latched term/pre/periodic = 0.
- Reset asserted mid-RUN forces all of the above immediately (asynchronously). No evt is issued.
- Command accepted at edge ending cycle T:
  - Cycle T+1: busy = 1, lfsr = seed.
  - The first step occurs at the edge ending cycle T+1+pre, given en held high.
- evt is registered. It is high in the cycle following the matching step edge, which is the same cycle lfsr shows the seed again.
- One-shot: cmd_ready returns to 1 in the same cycle evt is high. A new command may be accepted in that cycle.
- stop sampled at edge E: busy = 0 and cmd_ready = 1 from cycle E+1.

## Test plan

- Reset, then cmd term = 7'b0100000, pre = 0, one-shot, en = 1, accepted in cycle T:
  - lfsr shows 0000010, 0000100, 0001000, 0010000 in cycles T+2..T+5.
  - evt = 1 only in T+6, with lfsr = 0000001 and cmd_ready = 1.
- Same term, periodic, pre = 2: evt pulses every 15 cycles (5 steps × 3) until stop. On stop, busy drops the next cycle and there are no further evt pulses.
- Periodic, term = 7'b1000001 (N = 6), pre = 0, en toggled 1010… :
  - evt interval is 12 cycles.
  - lfsr and pre_cnt freeze in en = 0 cycles.
- cmd term = 0: err = 1, busy stays 0, cmd_ready stays 1. A following valid command clears err and runs.
- term = seed (0000001), pre = 0, periodic:
  - evt period is 127 cycles.
  - All 127 nonzero lfsr values appear exactly once per period.
- Corner cases:
  - stop asserted in the match cycle: no evt.
  - rst_n pulsed low mid-RUN: all outputs return to reset values at once.
  - cmd_valid held during RUN: ignored, then accepted on the first IDLE cycle.

Source files
------------

// File: rtl/lfsr_tick_sched.sv
// Programmable event scheduler: a 7-bit maximal-length LFSR advanced on prescaled enable ticks,
// pulsing evt each time the sequence reaches a programmed terminal pattern.
module lfsr_tick_sched #(
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_term,
  input  logic [PRE_W-1:0] cmd_pre,
  input  logic             cmd_periodic,
  input  logic             stop,
  output logic             busy,
  output logic             evt,
  output logic             err,
  output logic [6:0]       lfsr
);

  localparam logic [6:0] Seed = 7'b0000001;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [6:0]       lfsr_q, lfsr_d;
  logic [6:0]       lfsr_step;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [6:0]       term_q, term_d;
  logic             periodic_q, periodic_d;
  logic             evt_q, evt_d;
  logic             err_q, err_d;

  // x^7 + x^6 + 1: period 127, all-zero state unreachable from the seed
  assign lfsr_step = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    pre_cnt_d  = pre_cnt_q;
    pre_d      = pre_q;
    term_d     = term_q;
    periodic_d = periodic_q;
    evt_d      = 1'b0;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          term_d     = cmd_term;
          pre_d      = cmd_pre;
          periodic_d = cmd_periodic;
          if (cmd_term == 7'd0) begin
            err_d = 1'b1;
          end else begin
            err_d     = 1'b0;
            lfsr_d    = Seed;
            pre_cnt_d = cmd_pre;
            state_d   = StRun;
          end
        end
      end
      StRun: begin
        // stop takes priority over a coincident match, suppressing its event
        if (stop) begin
          state_d = StIdle;
        end else if (en) begin
          if (pre_cnt_q != '0) begin
            pre_cnt_d = pre_cnt_q - PRE_W'(1);
          end else begin
            pre_cnt_d = pre_q;
            if (lfsr_step == term_q) begin
              lfsr_d = Seed;
              evt_d  = 1'b1;
              if (!periodic_q) state_d = StIdle;
            end else begin
              lfsr_d = lfsr_step;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lfsr_q     <= Seed;
      pre_cnt_q  <= '0;
      pre_q      <= '0;
      term_q     <= '0;
      periodic_q <= 1'b0;
      evt_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      pre_cnt_q  <= pre_cnt_d;
      pre_q      <= pre_d;
      term_q     <= term_d;
      periodic_q <= periodic_d;
      evt_q      <= evt_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign evt       = evt_q;
  assign err       = err_q;
  assign lfsr      = lfsr_q;

endmodule

// File: tb/tb_lfsr_tick_sched.sv
// Bench for lfsr_tick_sched: directed scenarios plus random traffic, every cycle compared against
// a model that tracks position in the LFSR sequence and counts enabled cycles per step.
module tb_lfsr_tick_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_term;
  logic [7:0] cmd_pre;
  logic       cmd_periodic;
  logic       stop;
  logic       busy;
  logic       evt;
  logic       err;
  logic [6:0] lfsr;

  lfsr_tick_sched #(.PRE_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_term    (cmd_term),
    .cmd_pre     (cmd_pre),
    .cmd_periodic(cmd_periodic),
    .stop        (stop),
    .busy        (busy),
    .evt         (evt),
    .err         (err),
    .lfsr        (lfsr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit toggle_en = 1'b0;

  // sequence table: seq[k] is the counter value k steps after the seed
  logic [6:0] seq [127];

  bit m_run, m_evt, m_err, m_periodic;
  int m_idx, m_phase, m_pre, m_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int find_n(input logic [6:0] t);
    for (int j = 1; j <= 127; j++) if (seq[j % 127] == t) return j;
    return 127;
  endfunction

  task automatic model_reset();
    m_run = 0; m_evt = 0; m_err = 0; m_periodic = 0;
    m_idx = 0; m_phase = 0; m_pre = 0; m_n = 127;
  endtask

  task automatic model_update();
    bit ev;
    ev = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!m_run) begin
      if (cmd_valid) begin
        m_pre = int'(cmd_pre);
        m_periodic = cmd_periodic;
        if (cmd_term == 7'd0) m_err = 1;
        else begin
          m_err = 0; m_n = find_n(cmd_term); m_idx = 0; m_phase = 0; m_run = 1;
        end
      end
    end else if (stop) begin
      m_run = 0;
    end else if (en) begin
      m_phase++;
      if (m_phase > m_pre) begin
        m_phase = 0;
        m_idx++;
        if (m_idx == m_n) begin
          m_idx = 0;
          ev = 1;
          if (!m_periodic) m_run = 0;
        end
      end
    end
    m_evt = ev;
  endtask

  function automatic logic [31:0] model_outs();
    return {21'd0, ~m_run, m_run, m_evt, m_err, seq[m_idx]};
  endfunction

  // compare current cycle, advance model through the edge, land 1 time unit after it
  task automatic step_cycle();
    @(negedge clk);
    chk("outs", {21'd0, cmd_ready, busy, evt, err, lfsr}, model_outs());
    model_update();
    @(posedge clk);
    #1;
    if (toggle_en) en = ~en;
  endtask

  task automatic wait_evt(input string tag, input int max, output int k);
    k = 0;
    do begin
      step_cycle();
      k++;
    end while (!evt && k < max);
    chk(tag, evt, 1'b1);
  endtask

  task automatic issue(input logic [6:0] t, input logic [7:0] p, input logic per);
    cmd_term = t; cmd_pre = p; cmd_periodic = per; cmd_valid = 1'b1;
    step_cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step_cycle();
    stop = 1'b0;
    chk("stop_busy", busy, 1'b0);
    chk("stop_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    int k, ecount, distinct;
    bit seen [128];
    logic [6:0] exp_l [4];
    exp_l[0] = 7'h02; exp_l[1] = 7'h04; exp_l[2] = 7'h08; exp_l[3] = 7'h10;

    seq[0] = 7'h01;
    for (int i = 1; i < 127; i++) seq[i] = {seq[i-1][5:0], seq[i-1][6] ^ seq[i-1][5]};

    rst_n = 1'b0; en = 1'b1; cmd_valid = 1'b0; cmd_term = '0; cmd_pre = '0;
    cmd_periodic = 1'b0; stop = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {cmd_ready, busy, evt, err, lfsr}, {4'b1000, 7'h01});
    rst_n = 1'b1;
    step_cycle();

    // one-shot, pre = 0, term = 0100000
    issue(7'h20, 8'd0, 1'b0);
    chk("os_seed", lfsr, 7'h01);
    chk("os_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step_cycle();
      chk("os_lfsr", lfsr, exp_l[i]);
      chk("os_noevt", evt, 1'b0);
    end
    step_cycle();
    chk("os_evt", {evt, cmd_ready, lfsr}, {2'b11, 7'h01});
    step_cycle();
    chk("os_evt_once", evt, 1'b0);

    // periodic, pre = 2: 5 steps x 3 cycles
    issue(7'h20, 8'd2, 1'b1);
    wait_evt("per_first", 40, k);
    for (int i = 0; i < 2; i++) begin
      wait_evt("per_evt", 40, k);
      chk("per_interval", k, 15);
    end
    step_cycle();
    do_stop();
    ecount = 0;
    for (int i = 0; i < 40; i++) begin
      step_cycle();
      if (evt) ecount++;
    end
    chk("no_evt_after_stop", ecount, 0);

    // en toggling, term = 1000001 (N = 6), pre = 0
    issue(7'h41, 8'd0, 1'b1);
    toggle_en = 1'b1;
    wait_evt("tog_first", 40, k);
    wait_evt("tog_evt", 40, k);
    chk("tog_interval", k, 12);
    toggle_en = 1'b0;
    en = 1'b1;
    do_stop();

    // zero terminal pattern
    issue(7'h00, 8'd3, 1'b1);
    chk("err_set", {err, busy, cmd_ready}, 3'b101);
    step_cycle();
    chk("err_sticky", {err, busy}, 2'b10);
    issue(7'h04, 8'd0, 1'b0);
    chk("err_clear", {err, busy}, 2'b01);
    wait_evt("err_run_evt", 20, k);

    // term = seed: full period visiting every nonzero value once
    issue(7'h01, 8'd0, 1'b1);
    wait_evt("full_first", 200, k);
    for (int i = 0; i < 128; i++) seen[i] = 0;
    distinct = 0;
    for (int i = 0; i < 127; i++) begin
      if (!seen[lfsr]) distinct++;
      seen[lfsr] = 1;
      step_cycle();
    end
    chk("full_evt", evt, 1'b1);
    chk("full_distinct", distinct, 127);
    chk("full_zero_unseen", seen[0], 1'b0);
    do_stop();

    // stop coinciding with a match
    issue(7'h04, 8'd0, 1'b1);
    step_cycle();
    chk("sm_lfsr", lfsr, 7'h02);
    stop = 1'b1;
    step_cycle();
    stop = 1'b0;
    chk("sm_noevt", {evt, busy, lfsr}, {2'b00, 7'h02});

    // async reset mid-run
    issue(7'h20, 8'd1, 1'b1);
    repeat (3) step_cycle();
    rst_n = 1'b0;
    #2;
    chk("arst_outs", {cmd_ready, busy, evt, err, lfsr}, {4'b1000, 7'h01});
    model_reset();
    step_cycle();
    rst_n = 1'b1;
    step_cycle();

    // cmd_valid held through a one-shot run
    cmd_term = 7'h04; cmd_pre = 8'd1; cmd_periodic = 1'b0; cmd_valid = 1'b1;
    step_cycle();
    chk("hold_busy", busy, 1'b1);
    wait_evt("hold_evt", 20, k);
    chk("hold_ready", cmd_ready, 1'b1);
    step_cycle();
    chk("hold_reaccept", {busy, lfsr}, {1'b1, 7'h01});
    cmd_valid = 1'b0;
    stop = 1'b1;
    step_cycle();
    stop = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 4) != 0);
      stop = ($urandom_range(0, 49) == 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) cmd_term = 7'd0;
      else if ($urandom_range(0, 3) != 0) cmd_term = seq[$urandom_range(0, 12)];
      else cmd_term = 7'($urandom);
      cmd_pre = 8'($urandom_range(0, 3));
      cmd_periodic = 1'($urandom);
      step_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
